// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------------------------
// led_pattern_sequencer
//
// Drives the red LED bank with one of four animated patterns. A prescaler turns Clock into a
// step tick. Each tick either steps the active pattern or, if the switches ask for a different
// pattern, loads that pattern's seed. Pattern changes therefore only land on tick boundaries.
//
// Ports
//   Clock    in          system clock, all logic on posedge
//   Reset    in          synchronous, active-high, overrides everything
//   SW       in  [3:0]   [0] run, [2:1] pattern select, [3] fast speed
//   led      out [N-1:0] registered LED drive
//   tick     out         registered one-cycle pulse on each pattern step
//   mode     out [1:0]   registered active pattern (00 left, 01 right, 10 invert, 11 bounce)
//   running  out         registered, high while the sequencer is in RUN
// ---------------------------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int unsigned N_LEDS   = 18,
    parameter int unsigned DIV_BITS = 26
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [3:0]        SW,
    output logic [N_LEDS-1:0] led,
    output logic              tick,
    output logic [1:0]        mode,
    output logic              running
);

    typedef enum logic {StStop, StRun} state_e;

    localparam logic [1:0] ModeLeft   = 2'b00;
    localparam logic [1:0] ModeRight  = 2'b01;
    localparam logic [1:0] ModeInvert = 2'b10;
    localparam logic [1:0] ModeBounce = 2'b11;

    localparam logic DirLeft  = 1'b0;
    localparam logic DirRight = 1'b1;

    localparam logic [DIV_BITS-1:0] TermSlow = {DIV_BITS{1'b1}};
    localparam logic [DIV_BITS-1:0] TermFast = {2'b00, {(DIV_BITS-2){1'b1}}};
    localparam logic [DIV_BITS-1:0] CountOne = {{(DIV_BITS-1){1'b0}}, 1'b1};

    // Alternating pattern with bit0 lit: ...010101
    function automatic logic [N_LEDS-1:0] alt_seed();
        logic [N_LEDS-1:0] s;
        for (int i = 0; i < N_LEDS; i++) begin
            s[i] = (i % 2 == 0);
        end
        return s;
    endfunction

    localparam logic [N_LEDS-1:0] SeedLeft   = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] SeedRight  = {1'b1, {(N_LEDS-1){1'b0}}};
    localparam logic [N_LEDS-1:0] SeedInvert = alt_seed();
    localparam logic [N_LEDS-1:0] SeedBounce = SeedLeft;

    state_e              state_q, state_d;
    logic [DIV_BITS-1:0] count_q, count_d;
    logic                tick_q, tick_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic [1:0]          mode_q, mode_d;
    logic                dir_q, dir_d;
    logic                running_q, running_d;
    logic [DIV_BITS-1:0] term;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = 1'b0;
        led_d   = led_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        term    = SW[3] ? TermFast : TermSlow;

        unique case (state_q)
            StStop: begin
                count_d = '0;
                if (SW[0]) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!SW[0]) begin
                    state_d = StStop;
                    count_d = '0;
                end else if (count_q >= term) begin
                    // >= rather than == so a slow->fast switch with count beyond the fast
                    // terminal fires immediately instead of wrapping the counter.
                    count_d = '0;
                    tick_d  = 1'b1;
                    if (SW[2:1] != mode_q) begin
                        mode_d = SW[2:1];
                        dir_d  = DirLeft;
                        unique case (SW[2:1])
                            ModeLeft:   led_d = SeedLeft;
                            ModeRight:  led_d = SeedRight;
                            ModeInvert: led_d = SeedInvert;
                            ModeBounce: led_d = SeedBounce;
                            default:    led_d = SeedLeft;
                        endcase
                    end else begin
                        unique case (mode_q)
                            ModeLeft:   led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
                            ModeRight:  led_d = {led_q[0], led_q[N_LEDS-1:1]};
                            ModeInvert: led_d = ~led_q;
                            ModeBounce: begin
                                // Reverse at an end and take the first step back in the
                                // same tick, so the lit bit never dwells at the edge.
                                if (dir_q == DirLeft) begin
                                    if (led_q[N_LEDS-1]) begin
                                        dir_d = DirRight;
                                        led_d = led_q >> 1;
                                    end else begin
                                        led_d = led_q << 1;
                                    end
                                end else begin
                                    if (led_q[0]) begin
                                        dir_d = DirLeft;
                                        led_d = led_q << 1;
                                    end else begin
                                        led_d = led_q >> 1;
                                    end
                                end
                            end
                            default: led_d = led_q;
                        endcase
                    end
                end else begin
                    count_d = count_q + CountOne;
                end
            end
            default: begin
                state_d = StStop;
                count_d = '0;
            end
        endcase

        running_d = (state_d == StRun);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StStop;
            count_q   <= '0;
            tick_q    <= 1'b0;
            led_q     <= SeedLeft;
            mode_q    <= ModeLeft;
            dir_q     <= DirLeft;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            led_q     <= led_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            running_q <= running_d;
        end
    end

    assign led     = led_q;
    assign tick    = tick_q;
    assign mode    = mode_q;
    assign running = running_q;

endmodule
